sobel_window_3x3: RTL
=====================

Name: sobel_window_3x3

Overview:
- Consumer stage directly downstream of the line-buffer chain.
- Inputs: the current pixel row plus the two delayed rows, one pixel per beat. The block assembles a 3x3 window from them.
- Computes the Sobel gradient magnitude |Gx|+|Gy|, saturates it to pixel width, and produces a thresholded binary edge flag.
- Tracks column position so that windows spanning a line boundary are never emitted.

Parameters:
- width, 8, pixel bit width for all row inputs, threshold and edge_mag.
- img_width, 1280, pixels per line (minimum 3). The column counter is clog2(img_width) bits.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  the three row inputs carry a valid column this cycle
- row_top  input  width  pixel from the line two lines earlier (oldest row)
- row_mid  input  width  pixel from the line one line earlier
- row_bot  input  width  pixel from the current line (newest row)
- threshold  input  width  edge threshold, unsigned
- valid_out  output  1  edge_mag and edge_bin carry a new result this cycle
- edge_mag  output  width  saturated |Gx|+|Gy| of the window
- edge_bin  output  1  1 when the unsaturated magnitude is strictly greater than threshold

Behaviour:
- Reset (rst high at a clock edge) clears:
  - column counter
  - all window registers
  - all pipeline data and valid flags
  - valid_out=0, edge_mag=0, edge_bin=0
- Reset mid-line discards in-flight results. The next accepted beat is treated as column 0.
- Window: 3x3 registers p[r][j], with r=0 top, 1 mid, 2 bot and j=2 newest. On each valid_in beat every row shifts: p[r][0]<=p[r][1], p[r][1]<=p[r][2], p[r][2]<=input. Window registers hold when valid_in=0.
- Column counter col: increments on each valid_in beat and wraps from img_width-1 to 0. It holds when valid_in=0. Gaps of any length between beats are legal and do not affect results.
- A beat accepted at column c completes the window of columns c-2..c (centre c-1). That window is eligible only if c>=2, giving img_width-2 results per line. Beats at c=0 and c=1 produce no output; their windows would mix the previous line's tail.
- Arithmetic, all signed width+3 bits:
  - Gx = (p0[2]+2*p1[2]+p2[2]) - (p0[0]+2*p1[0]+p2[0])
  - Gy = (p2[0]+2*p2[1]+p2[2]) - (p0[0]+2*p0[1]+p0[2])
  - mag = |Gx|+|Gy|, unsigned width+3 bits, maximum 8*(2^width-1), no overflow.
  - edge_mag = min(mag, 2^width-1).
  - edge_bin = (mag > threshold), using the unsaturated mag; threshold is zero-extended.
- Pipeline: fixed, non-stalling, one beat per cycle maximum.
  - Stage 1: window shift.
  - Stage 2: Gx and Gy registered.
  - Stage 3: mag, saturation and compare registered into the outputs.
  - An eligible beat accepted at edge t gives valid_out=1 for exactly one cycle after edge t+3.
  - Results leave in beat order with gaps preserved.
- threshold is sampled at the stage-3 edge. A change takes effect on the next result computed.
- When valid_out=0, edge_mag and edge_bin hold their last values.
- No back-pressure. The downstream stage must accept every valid_out beat.

Test Plan:
- Flat image (img_width=8, all rows 50, continuous valid_in for 3 lines, threshold=0) -> 6 valid_out pulses per line; every edge_mag=0, edge_bin=0. First pulse occurs 3 cycles after the edge accepting column 2.
- Vertical step (all rows: cols 0-3 = 10, cols 4-7 = 200; threshold=100; img_width=8) -> Gx=760, Gy=0.
  - Windows centred at cols 3 and 4: edge_mag=255 (saturated), edge_bin=1.
  - All other windows: edge_mag=0, edge_bin=0.
- Horizontal step (row_top=row_mid=0, row_bot=5 everywhere, threshold=20) -> every result Gy=20: edge_mag=20, edge_bin=0. With threshold=19 -> edge_bin=1.
- Gapped input (valid_in toggling 1,0,1,0 over a flat-50 line, img_width=8) -> same 6 results as the continuous case. valid_out pulses are spaced 2 cycles apart, and the latency from each eligible beat is 3.
- Line wrap (line A all 0, then line B all 100 on all rows, img_width=8) -> no valid_out for line B columns 0 and 1. Line B column 2 gives edge_mag=0. No result ever mixes A and B pixels.
- Mid-line reset (assert rst at column 5 with 2 results in flight) -> valid_out=0 and outputs=0 from the next edge. In-flight results are dropped. The following beats restart at column 0, so the first output appears only after 3 new beats.

Source files
------------

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
// Builds a 3x3 pixel window from three line-buffer rows and produces the
// Sobel gradient magnitude |Gx|+|Gy|, saturated to pixel width, together
// with a binary edge flag (unsaturated magnitude > threshold).
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   valid_in   row_top/row_mid/row_bot carry one column this cycle
//   row_top    oldest row pixel (two lines back)
//   row_mid    middle row pixel (one line back)
//   row_bot    newest row pixel (current line)
//   threshold  unsigned edge threshold
//   valid_out  edge_mag/edge_bin carry a new result this cycle
//   edge_mag   saturated gradient magnitude
//   edge_bin   1 when the unsaturated magnitude exceeds threshold
//
// Timing: a beat accepted at edge t is captured at t, shifted into the
// window at t+1, turned into Gx/Gy at t+2 and into the outputs at t+3.
// Only beats at column >= 2 produce a result, so a window never spans
// two lines.
module sobel_window_3x3 #(
  parameter int width     = 8,
  parameter int img_width = 1280
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [width-1:0] row_top,
  input  logic [width-1:0] row_mid,
  input  logic [width-1:0] row_bot,
  input  logic [width-1:0] threshold,
  output logic             valid_out,
  output logic [width-1:0] edge_mag,
  output logic             edge_bin
);

  localparam int col_w = $clog2(img_width);
  localparam int acc_w = width + 3;
  localparam logic [col_w-1:0] col_last = col_w'(img_width - 1);
  localparam logic [acc_w-1:0] sat_max  = {3'b000, {width{1'b1}}};

  // Weighted 1-2-1 tap sum, zero-extended so it never overflows acc_w.
  function automatic logic [acc_w-1:0] tap_sum(
    input logic [width-1:0] a,
    input logic [width-1:0] b,
    input logic [width-1:0] c
  );
    tap_sum = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  // Magnitude of a two's-complement value; |-1020| still fits in acc_w.
  function automatic logic [acc_w-1:0] abs_val(input logic signed [acc_w-1:0] v);
    logic [acc_w-1:0] u;
    u = v;
    if (u[acc_w-1]) begin
      abs_val = ~u + {{(acc_w-1){1'b0}}, 1'b1};
    end else begin
      abs_val = u;
    end
  endfunction

  // Input capture stage
  logic                      in_valid_q, in_valid_d;
  logic                      in_elig_q,  in_elig_d;
  logic [2:0][width-1:0]     in_row_q,   in_row_d;   // [0]=top [1]=mid [2]=bot
  logic [col_w-1:0]          col_q,      col_d;
  // Window stage: win[r][j], r=0 top..2 bot, j=2 newest column
  logic [2:0][2:0][width-1:0] win_q,     win_d;
  logic                      s1_valid_q, s1_valid_d;
  // Gradient stage
  logic signed [acc_w-1:0]   gx_q,       gx_d;
  logic signed [acc_w-1:0]   gy_q,       gy_d;
  logic                      s2_valid_q, s2_valid_d;
  // Output stage
  logic                      valid_out_q, valid_out_d;
  logic [width-1:0]          edge_mag_q,  edge_mag_d;
  logic                      edge_bin_q,  edge_bin_d;
  logic [acc_w-1:0]          mag;

  // Next-state logic for every pipeline stage
  always_comb begin
    in_valid_d  = valid_in;
    in_elig_d   = 1'b0;
    in_row_d    = in_row_q;
    col_d       = col_q;
    win_d       = win_q;
    s1_valid_d  = in_valid_q & in_elig_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    s2_valid_d  = s1_valid_q;
    valid_out_d = s2_valid_q;
    edge_mag_d  = edge_mag_q;
    edge_bin_d  = edge_bin_q;
    mag         = abs_val(gx_q) + abs_val(gy_q);

    // Column tracking: columns 0 and 1 complete windows that still hold
    // the previous line's tail, so they are marked ineligible.
    if (valid_in) begin
      in_row_d  = {row_bot, row_mid, row_top};
      in_elig_d = (col_q >= col_w'(2));
      if (col_q == col_last) begin
        col_d = '0;
      end else begin
        col_d = col_q + col_w'(1);
      end
    end else begin
      col_d = col_q;
    end

    // Window shift, holding across gaps
    if (in_valid_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = in_row_q[r];
      end
    end else begin
      win_d = win_q;
    end

    // Gradients from the freshly shifted window
    if (s1_valid_q) begin
      gx_d = $signed(tap_sum(win_q[0][2], win_q[1][2], win_q[2][2])
                   - tap_sum(win_q[0][0], win_q[1][0], win_q[2][0]));
      gy_d = $signed(tap_sum(win_q[2][0], win_q[2][1], win_q[2][2])
                   - tap_sum(win_q[0][0], win_q[0][1], win_q[0][2]));
    end else begin
      gx_d = gx_q;
      gy_d = gy_q;
    end

    // Saturation and threshold; outputs hold when no result is produced
    if (s2_valid_q) begin
      if (mag > sat_max) begin
        edge_mag_d = {width{1'b1}};
      end else begin
        edge_mag_d = mag[width-1:0];
      end
      edge_bin_d = (mag > {3'b000, threshold});
    end else begin
      edge_mag_d = edge_mag_q;
      edge_bin_d = edge_bin_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q  <= 1'b0;
      in_elig_q   <= 1'b0;
      in_row_q    <= '0;
      col_q       <= '0;
      win_q       <= '0;
      s1_valid_q  <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      s2_valid_q  <= 1'b0;
      valid_out_q <= 1'b0;
      edge_mag_q  <= '0;
      edge_bin_q  <= 1'b0;
    end else begin
      in_valid_q  <= in_valid_d;
      in_elig_q   <= in_elig_d;
      in_row_q    <= in_row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      s1_valid_q  <= s1_valid_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      s2_valid_q  <= s2_valid_d;
      valid_out_q <= valid_out_d;
      edge_mag_q  <= edge_mag_d;
      edge_bin_q  <= edge_bin_d;
    end
  end

  assign valid_out = valid_out_q;
  assign edge_mag  = edge_mag_q;
  assign edge_bin  = edge_bin_q;

endmodule
